// File: rtl/cardjitsu_round_ctrl.sv
`default_nettype none
// cardjitsu_round_ctrl: debounces the element buttons, draws an LFSR CPU card, resolves rounds,
// keeps score and sequences the LED reveal/result display.  Rev 1.0
module cardjitsu_round_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SHOW_CYCLES     = 32,
  parameter int WIN_SCORE       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_0,
  input  logic       btn_1,
  input  logic       btn_2,
  input  logic [3:0] sw,
  output logic [3:0] leds,
  output logic       led6_r,
  output logic       led6_g,
  output logic       led6_b
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TM_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] TM_LAST = TM_W'(SHOW_CYCLES - 1);
  localparam logic [1:0] WIN_PTS  = 2'(WIN_SCORE);
  localparam logic [1:0] EL_FIRE  = 2'd0;
  localparam logic [1:0] EL_WATER = 2'd1;
  localparam logic [1:0] EL_SNOW  = 2'd2;
  localparam logic [2:0] RGB_OFF  = 3'b000;
  localparam logic [2:0] RGB_RED  = 3'b100;
  localparam logic [2:0] RGB_GRN  = 3'b010;
  localparam logic [2:0] RGB_BLU  = 3'b001;
  localparam logic [2:0] RGB_YEL  = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_REVEAL = 3'd2,
    ST_RESULT = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OUT_TIE  = 2'd0,
    OUT_WIN  = 2'd1,
    OUT_LOSS = 2'd2
  } outcome_t;

  logic [2:0]      btn_s1, btn_s2, btn_db, btn_db_q;
  logic [3:0]      sw_s1, sw_s2;
  logic [7:0]      lfsr;
  state_t          state;
  logic [TM_W-1:0] timer;
  logic [1:0]      p_score, c_score, p_next, c_next;
  logic [1:0]      p_elem, c_elem, press_elem, cpu_elem_now;
  logic [3:0]      p_pow, c_pow;
  logic [2:0]      rgb, press_ev;
  logic            press;
  outcome_t        outcome;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      btn_db_q <= '0;
      lfsr     <= 8'hA5;
    end else begin
      btn_s1   <= {btn_2, btn_1, btn_0};
      btn_s2   <= btn_s1;
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
      btn_db_q <= btn_db;
      lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // The debounced level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  for (genvar i = 0; i < 3; i++) begin : g_debounce
    logic [DB_W-1:0] cnt;
    logic            db;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
        db  <= 1'b0;
      end else if (btn_s2[i] != db) begin
        if (cnt == DB_LAST) begin
          cnt <= '0;
          db  <= btn_s2[i];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
    assign btn_db[i] = db;
  end

  assign press_ev     = btn_db & ~btn_db_q;
  assign press        = |press_ev;
  assign cpu_elem_now = (lfsr[1:0] == 2'd3) ? EL_FIRE : lfsr[1:0];

  always_comb begin
    press_elem = EL_SNOW;
    if (press_ev[0])      press_elem = EL_FIRE;
    else if (press_ev[1]) press_elem = EL_WATER;
  end

  always_comb begin
    outcome = OUT_TIE;
    if (p_elem == c_elem) begin
      if (p_pow > c_pow)      outcome = OUT_WIN;
      else if (p_pow < c_pow) outcome = OUT_LOSS;
    end else if ((p_elem == EL_FIRE  && c_elem == EL_SNOW)  ||
                 (p_elem == EL_SNOW  && c_elem == EL_WATER) ||
                 (p_elem == EL_WATER && c_elem == EL_FIRE)) begin
      outcome = OUT_WIN;
    end else begin
      outcome = OUT_LOSS;
    end
  end

  assign p_next = p_score + 2'(outcome == OUT_WIN);
  assign c_next = c_score + 2'(outcome == OUT_LOSS);

  function automatic logic [2:0] elem_rgb(input logic [1:0] e);
    case (e)
      EL_WATER: return RGB_BLU;
      EL_SNOW:  return RGB_GRN;
      default:  return RGB_RED;
    endcase
  endfunction

  function automatic logic [2:0] outcome_rgb(input outcome_t o);
    case (o)
      OUT_WIN:  return RGB_GRN;
      OUT_LOSS: return RGB_RED;
      default:  return RGB_YEL;
    endcase
  endfunction

  // Outputs are loaded together with the state they belong to, so they track the state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      timer   <= '0;
      p_score <= '0;
      c_score <= '0;
      p_elem  <= '0;
      p_pow   <= '0;
      c_elem  <= '0;
      c_pow   <= '0;
      leds    <= '0;
      rgb     <= RGB_OFF;
    end else begin
      unique case (state)
        ST_IDLE: begin
          leds <= {p_score, c_score};
          rgb  <= RGB_OFF;
          if (btn_db == 3'b000) begin
            state <= ST_ARMED;
            leds  <= sw_s2;
          end
        end
        ST_ARMED: begin
          leds <= sw_s2;
          rgb  <= RGB_OFF;
          if (press) begin
            state  <= ST_REVEAL;
            timer  <= '0;
            p_elem <= press_elem;
            p_pow  <= sw_s2;
            c_elem <= cpu_elem_now;
            c_pow  <= lfsr[7:4];
            leds   <= lfsr[7:4];
            rgb    <= elem_rgb(cpu_elem_now);
          end
        end
        ST_REVEAL: begin
          if (timer == TM_LAST) begin
            state   <= ST_RESULT;
            timer   <= '0;
            p_score <= p_next;
            c_score <= c_next;
            leds    <= {p_next, c_next};
            rgb     <= outcome_rgb(outcome);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESULT: begin
          if (timer == TM_LAST) begin
            timer <= '0;
            if (p_score == WIN_PTS || c_score == WIN_PTS) begin
              state <= ST_OVER;
              leds  <= (p_score == WIN_PTS) ? 4'hF : 4'h0;
              rgb   <= (p_score == WIN_PTS) ? RGB_GRN : RGB_RED;
            end else begin
              state <= ST_IDLE;
              leds  <= {p_score, c_score};
              rgb   <= RGB_OFF;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_OVER: begin
          if (press) begin
            state   <= ST_IDLE;
            p_score <= '0;
            c_score <= '0;
            leds    <= 4'h0;
            rgb     <= RGB_OFF;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign {led6_r, led6_g, led6_b} = rgb;

endmodule
`default_nettype wire

// File: tb/tb_cardjitsu_round_ctrl.sv
`default_nettype none
// tb_cardjitsu_round_ctrl: rule-level game model predicts cycle-stamped LED/RGB values;
// a monitor compares them against the DUT at each falling edge.
module tb_cardjitsu_round_ctrl;

  localparam int D = 8;
  localparam int S = 12;
  localparam int W = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn;
  logic [3:0] sw;
  logic [3:0] leds;
  logic       led_r, led_g, led_b;

  cardjitsu_round_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .SHOW_CYCLES    (S),
    .WIN_SCORE      (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_0 (btn[0]),
    .btn_1 (btn[1]),
    .btn_2 (btn[2]),
    .sw    (sw),
    .leds  (leds),
    .led6_r(led_r),
    .led6_g(led_g),
    .led6_b(led_b)
  );

  always #5 clk = ~clk;

  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] leds;
    logic [2:0] rgb;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Game model state
  int base, armed_at, over_at, last_rel, p, c;
  bit over;

  task automatic expect_at(input int cyc, input logic [3:0] l, input logic [2:0] rgb, input string nm);
    exp_t e;
    e.cyc = cyc; e.leds = l; e.rgb = rgb; e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc <= tcyc) begin
          n_vec++;
          if (q[i].cyc < tcyc) begin
            n_miss++;
            $display("FAIL %s: slot for cycle %0d passed unchecked (now %0d)", q[i].name, q[i].cyc, tcyc);
          end else if (leds !== q[i].leds || {led_r, led_g, led_b} !== q[i].rgb) begin
            n_miss++;
            $display("FAIL %s @cycle %0d: leds=%h rgb=%b, required leds=%h rgb=%b",
                     q[i].name, tcyc, leds, {led_r, led_g, led_b}, q[i].leds, q[i].rgb);
          end
          q.delete(i);
        end
      end
    end
  end

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] lfsr_at(input int cyc);
    logic [7:0] l = 8'hA5;
    for (int n = 0; n < cyc - base; n++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction

  function automatic int elem_of(input logic [7:0] l);
    return (l[1:0] == 2'd3) ? 0 : int'(l[1:0]);
  endfunction

  // 0 fire, 1 water, 2 snow; each element beats the one two steps ahead of it mod 3.
  function automatic int resolve(input int pe, input int pp, input int ce, input int cp);
    if (pe == ce) return (pp > cp) ? 1 : ((pp < cp) ? -1 : 0);
    return (ce == (pe + 2) % 3) ? 1 : -1;
  endfunction

  function automatic logic [2:0] elem_color(input int e);
    return (e == 0) ? 3'b100 : ((e == 1) ? 3'b001 : 3'b010);
  endfunction

  function automatic logic [2:0] result_color(input int r);
    return (r > 0) ? 3'b010 : ((r < 0) ? 3'b100 : 3'b110);
  endfunction

  function automatic int kmin();
    int ready = over ? over_at : armed_at;
    return imax(imax(tcyc + 1, ready - 2 - D), last_rel + D + 1);
  endfunction

  task automatic goto(input int k);
    while (tcyc < k) @(negedge clk);
  endtask

  // Raises the raw buttons at cycle k; the debounced event lands at k+2+D.
  task automatic press(input logic [2:0] mask, input logic [3:0] swv, input int k);
    int ev, pe, ce, cp, res;
    logic [7:0] l;
    ev = k + 2 + D;
    pe = mask[0] ? 0 : (mask[1] ? 1 : 2);
    if (over) begin
      expect_at(ev, (p == W) ? 4'hF : 4'h0, (p == W) ? 3'b010 : 3'b100, "over_hold");
      expect_at(ev + 1, 4'h0, 3'b000, "over_clear");
      p = 0; c = 0; over = 0;
      armed_at = ev + 4 + D;
    end else begin
      l  = lfsr_at(ev);
      ce = elem_of(l);
      cp = int'(l[7:4]);
      expect_at(ev, swv, 3'b000, "armed_sw");
      expect_at(ev + 1, l[7:4], elem_color(ce), "reveal_cpu");
      res = resolve(pe, int'(swv), ce, cp);
      if (res > 0) p++;
      else if (res < 0) c++;
      expect_at(ev + 1 + S, {2'(p), 2'(c)}, result_color(res), "result");
      if (p == W || c == W) begin
        over    = 1;
        over_at = ev + 1 + 2 * S;
        expect_at(over_at, (p == W) ? 4'hF : 4'h0, (p == W) ? 3'b010 : 3'b100, "over_entry");
      end else begin
        expect_at(ev + 1 + 2 * S, {2'(p), 2'(c)}, 3'b000, "idle_score");
        armed_at = imax(ev + 1 + 2 * S, ev + 3 + D) + 1;
      end
    end
    goto(k);
    sw  = swv;
    btn = mask;
    goto(ev + 1);
    btn = 3'b000;
    last_rel = ev + 1;
  endtask

  // Picks the earliest legal press cycle whose CPU card has the wanted element.
  task automatic aim(input int want_ce, input bit headroom, output int k, output int ce, output int cp);
    logic [7:0] l;
    int k0 = kmin();
    k = k0;
    for (int g = 0; g < 256; g++) begin
      l = lfsr_at(k0 + g + 2 + D);
      if ((want_ce < 0 || elem_of(l) == want_ce) && (!headroom || l[7:4] != 4'hF)) begin
        k = k0 + g;
        break;
      end
    end
    l  = lfsr_at(k + 2 + D);
    ce = elem_of(l);
    cp = int'(l[7:4]);
  endtask

  task automatic glitch();
    int k = kmin();
    expect_at(k + D + 2, sw, 3'b000, "glitch_armed");
    expect_at(k + D + 6, sw, 3'b000, "glitch_no_reveal");
    goto(k);
    btn = 3'b001;
    goto(k + D - 1);
    btn = 3'b000;
    last_rel = k + D - 1;
  endtask

  task automatic do_reset(input int m);
    goto(m);
    rst = 1'b1;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].cyc > m) q.delete(i);
    expect_at(m + 1, 4'h0, 3'b000, "async_reset");
    goto(m + 2);
    rst = 1'b0;
    base = m + 2; armed_at = m + 3; p = 0; c = 0; over = 0;
  endtask

  initial begin
    int k, ce, cp;
    btn = 3'b000; sw = 4'h0; rst = 1'b1;
    base = 0; armed_at = 0; over_at = 0; last_rel = -100; p = 0; c = 0; over = 0;
    expect_at(2, 4'h0, 3'b000, "reset_outputs");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = tcyc;
    armed_at = tcyc + 1;
    expect_at(tcyc + 1, 4'h0, 3'b000, "armed_after_reset");

    aim(2, 1'b0, k, ce, cp);                      // fire vs snow with sw = 0
    press(3'b001, 4'h0, k);
    aim(1, 1'b0, k, ce, cp);                      // fire vs water
    press(3'b001, 4'($urandom_range(0, 15)), k);
    aim(-1, 1'b0, k, ce, cp);                     // same element, equal power
    press(3'(1 << ce), 4'(cp), k);
    aim(-1, 1'b1, k, ce, cp);                     // same element, one more power
    press(3'(1 << ce), 4'(cp + 1), k);
    glitch();
    aim(-1, 1'b0, k, ce, cp);                     // water and snow together
    press(3'b110, 4'($urandom_range(0, 15)), k);

    if (over) press(3'b001, sw, kmin());
    aim(-1, 1'b0, k, ce, cp);
    press(3'(1 << $urandom_range(0, 2)), 4'($urandom_range(0, 15)), k);
    do_reset(tcyc + 2);

    for (int i = 0; i < 3; i++) begin
      aim(-1, 1'b0, k, ce, cp);
      press(3'(1 << ((ce + 1) % 3)), 4'($urandom_range(0, 15)), k);
    end
    press(3'b100, sw, kmin());

    for (int i = 0; i < 40; i++) begin
      k = kmin() + int'($urandom_range(0, 6));
      press(3'($urandom_range(1, 7)), 4'($urandom_range(0, 15)), k);
    end

    for (int t = 0; t < 4000 && q.size() > 0; t++) @(negedge clk);
    foreach (q[i]) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: cycle %0d never reached (now %0d)", q[i].name, q[i].cyc, tcyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
